// File: rtl/tcdm_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tcdm_burst_master                                            |
// | Description : Strided burst initiator on a TCDM port. A write burst moves  |
// |               words from the wdata stream to memory. A read burst moves    |
// |               memory words into a small FIFO that drains to the rdata      |
// |               stream.                                                      |
// | Ports       : clk_i/rst_i        clock, synchronous active-high reset      |
// |               start_i..be_i      burst command, sampled on start in IDLE   |
// |               busy_o/done_o      burst in progress / one-cycle completion  |
// |               tcdm_*             TCDM initiator (req/gnt, r_valid resp.)   |
// |               wdata/wvalid/wready  write data stream in                    |
// |               rdata/rvalid/rready  read data stream out                    |
// |               proto_err_cnt_o    saturating count of r_valid seen in IDLE  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tcdm_burst_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             write_i,
  input  logic [31:0]      base_addr_i,
  input  logic [31:0]      stride_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [3:0]       be_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             tcdm_req_o,
  input  logic             tcdm_gnt_i,
  output logic [31:0]      tcdm_add_o,
  output logic             tcdm_wen_o,
  output logic [3:0]       tcdm_be_o,
  output logic [31:0]      tcdm_data_o,
  input  logic [31:0]      tcdm_r_data_i,
  input  logic             tcdm_r_valid_i,
  input  logic [31:0]      wdata_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [31:0]      rdata_o,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [7:0]       proto_err_cnt_o
);

  localparam int              c_AW    = $clog2(FIFO_DEPTH);
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW:0]   c_DEPTH = (c_CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_write;
  logic [31:0]      r_addr;
  logic [31:0]      r_stride;
  logic [LEN_W-1:0] r_len;
  logic [3:0]       r_be;
  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_received;
  logic [c_CW-1:0]  r_inflight;
  logic [c_CW-1:0]  r_fcnt;
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic             r_zero_done;
  logic [7:0]       r_err_cnt;

  logic w_grant;
  logic w_rsp;
  logic w_push;
  logic w_pop;
  logic w_last;
  logic w_all_rcvd;
  logic w_room;

  assign w_grant    = tcdm_req_o & tcdm_gnt_i;
  assign w_rsp      = tcdm_r_valid_i & busy_o;
  assign w_push     = w_rsp & ~r_write;
  assign w_pop      = rvalid_o & rready_i;
  assign w_last     = (r_issued == r_len - LEN_W'(1));
  assign w_all_rcvd = (r_received == r_len);
  // Outstanding read slots: words buffered plus words granted but unanswered.
  // Requesting only while this stays below the depth makes overflow impossible.
  assign w_room     = (({1'b0, r_fcnt} + {1'b0, r_inflight}) < c_DEPTH);

  assign tcdm_add_o      = r_addr;
  assign rvalid_o        = (r_fcnt != '0);
  assign rdata_o         = rvalid_o ? r_mem[r_rptr] : 32'h0;
  assign proto_err_cnt_o = r_err_cnt;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start_i && (len_i != '0)) w_state_nxt = c_ISSUE;
      c_ISSUE: if (w_grant && w_last)        w_state_nxt = c_WAIT;
      c_WAIT:  if (w_all_rcvd)               w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o      = 1'b0;
    done_o      = r_zero_done;
    tcdm_req_o  = 1'b0;
    tcdm_wen_o  = 1'b1;
    tcdm_be_o   = 4'h0;
    tcdm_data_o = 32'h0;
    wready_o    = 1'b0;
    case (r_state)
      c_ISSUE: begin
        busy_o = 1'b1;
        if (r_write) begin
          // Request mirrors the stream; the stream handshake is the grant.
          tcdm_req_o  = wvalid_i;
          tcdm_wen_o  = 1'b0;
          tcdm_be_o   = r_be;
          tcdm_data_o = wdata_i;
          wready_o    = wvalid_i & tcdm_gnt_i;
        end else begin
          tcdm_req_o  = w_room;
          tcdm_be_o   = 4'hF;
        end
      end
      c_WAIT: begin
        busy_o = 1'b1;
        done_o = w_all_rcvd;
      end
      default: ;
    endcase
  end

  // Burst bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_write     <= 1'b0;
      r_addr      <= 32'h0;
      r_stride    <= 32'h0;
      r_len       <= '0;
      r_be        <= 4'h0;
      r_issued    <= '0;
      r_received  <= '0;
      r_inflight  <= '0;
      r_zero_done <= 1'b0;
      r_err_cnt   <= 8'h0;
    end else begin
      r_zero_done <= 1'b0;
      if ((r_state == c_IDLE) && start_i) begin
        r_write     <= write_i;
        r_addr      <= base_addr_i;
        r_stride    <= stride_i;
        r_len       <= len_i;
        r_be        <= be_i;
        r_issued    <= '0;
        r_received  <= '0;
        r_inflight  <= '0;
        r_zero_done <= (len_i == '0);
      end
      // Running sum gives base + issued*stride without a multiplier.
      if (w_grant) begin
        r_addr   <= r_addr + r_stride;
        r_issued <= r_issued + LEN_W'(1);
      end
      if (w_rsp) r_received <= r_received + LEN_W'(1);
      if (w_grant && !r_write && !w_push)      r_inflight <= r_inflight + c_CW'(1);
      else if (!(w_grant && !r_write) && w_push) r_inflight <= r_inflight - c_CW'(1);
      if ((r_state == c_IDLE) && tcdm_r_valid_i && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'h1;
    end
  end

  // Read-data FIFO control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + c_CW'(1);
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - c_CW'(1);
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= tcdm_r_data_i;
  end

endmodule
`default_nettype wire
